alu_seq: RTL



---
 rtl/alu_pkg.sv | 30 +++
 rtl/alu_seq_if.sv | 28 ++
 rtl/alu_core.sv | 83 ++++++++
 rtl/alu_seq.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the sequential ALU.
//   - 4-bit opcode constants (legacy ALUCtrl encoding, MUL on code 7)
//   - FSM state type (IDLE / MUL)
//   - is_reserved(): true for the undefined codes 11, 13, 15
package alu_pkg;

  localparam logic [3:0] OP_SUB = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_OR  = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_DEC = 4'd4;
  localparam logic [3:0] OP_INC = 4'd5;
  localparam logic [3:0] OP_NOT = 4'd6;
  localparam logic [3:0] OP_MUL = 4'd7;
  localparam logic [3:0] OP_LSL = 4'd8;
  localparam logic [3:0] OP_SLE = 4'd9;
  localparam logic [3:0] OP_LSR = 4'd10;
  localparam logic [3:0] OP_ASL = 4'd12;
  localparam logic [3:0] OP_ASR = 4'd14;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_t;

  function automatic logic is_reserved(input logic [3:0] op);
    return (op == 4'd11) || (op == 4'd13) || (op == 4'd15);
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// alu_seq_if: operand/result handshake bundle for alu_seq.
//   master : issuer + consumer side (drives InValid/A/B/ALUCtrl/OutReady)
//   slave  : the ALU (drives InReady/OutValid/S/Overflow/Zero/Illegal)
interface alu_seq_if #(
  parameter int unsigned WIDTH = 16
);
  logic             InValid;
  logic             InReady;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [3:0]       ALUCtrl;
  logic             OutValid;
  logic             OutReady;
  logic [WIDTH-1:0] S;
  logic             Overflow;
  logic             Zero;
  logic             Illegal;

  modport master (
    output InValid, A, B, ALUCtrl, OutReady,
    input  InReady, OutValid, S, Overflow, Zero, Illegal
  );

  modport slave (
    input  InValid, A, B, ALUCtrl, OutReady,
    output InReady, OutValid, S, Overflow, Zero, Illegal
  );
endinterface

// File: rtl/alu_core.sv
// alu_core: combinational datapath for every single-cycle opcode plus the
// reserved codes. MUL (code 7) is handled by alu_seq; here it yields zeros.
//   a_i, b_i  : operands (b_i is the shift amount for shifts)
//   op_i      : opcode
//   s_o       : result
//   ovf_o     : overflow flag
//   illegal_o : opcode is reserved
module alu_core
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [3:0]       op_i,
  output logic [WIDTH-1:0] s_o,
  output logic             ovf_o,
  output logic             illegal_o
);
  localparam int unsigned       SHW  = $clog2(WIDTH);
  localparam logic [WIDTH-1:0]  WLIM = WIDTH'(WIDTH);
  localparam logic [WIDTH-1:0]  ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0]  MINV = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0]  MAXV = ~MINV;

  logic             big;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] add_r, sub_r, shl_r, shr_r, sra_r, asl_back;
  logic             msb;

  assign msb      = a_i[WIDTH-1];
  assign big      = (b_i >= WLIM);
  assign shamt    = b_i[SHW-1:0];
  assign add_r    = a_i + b_i;
  assign sub_r    = a_i - b_i;
  assign shl_r    = a_i << shamt;
  assign shr_r    = a_i >> shamt;
  assign sra_r    = $signed(a_i) >>> shamt;
  // Shifting the ASL result back arithmetically recovers A exactly when every
  // shifted-out bit and the new sign bit equal the original sign.
  assign asl_back = $signed(shl_r) >>> shamt;

  always_comb begin
    s_o       = '0;
    ovf_o     = 1'b0;
    illegal_o = 1'b0;
    unique case (op_i)
      OP_SUB: begin
        s_o   = sub_r;
        ovf_o = (msb != b_i[WIDTH-1]) && (sub_r[WIDTH-1] != msb);
      end
      OP_ADD: begin
        s_o   = add_r;
        ovf_o = (msb == b_i[WIDTH-1]) && (add_r[WIDTH-1] != msb);
      end
      OP_OR:  s_o = a_i | b_i;
      OP_AND: s_o = a_i & b_i;
      OP_NOT: s_o = ~a_i;
      OP_DEC: begin
        s_o   = a_i - ONE;
        ovf_o = (a_i == MINV);
      end
      OP_INC: begin
        s_o   = a_i + ONE;
        ovf_o = (a_i == MAXV);
      end
      OP_MUL: s_o = '0;
      OP_LSL: s_o = big ? '0 : shl_r;
      OP_LSR: s_o = big ? '0 : shr_r;
      OP_ASL: begin
        s_o   = big ? '0 : shl_r;
        // Everything shifted out: any nonzero A loses information or sign.
        ovf_o = big ? (|a_i) : (asl_back != a_i);
      end
      OP_ASR: s_o = big ? {WIDTH{msb}} : sra_r;
      OP_SLE: s_o = {{(WIDTH-1){1'b0}}, ($signed(a_i) <= $signed(b_i))};
      default: begin
        s_o       = '0;
        illegal_o = is_reserved(op_i);
      end
    endcase
  end
endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU with registered result and multi-cycle unsigned MUL.
//   Clk, Rst_n : clock, asynchronous active-low reset
//   bus        : alu_seq_if slave (InValid/InReady/A/B/ALUCtrl in,
//                OutValid/OutReady/S/Overflow/Zero/Illegal out)
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic        Clk,
  input  logic        Rst_n,
  alu_seq_if.slave    bus
);
  localparam int unsigned    SHW  = $clog2(WIDTH);
  localparam logic [SHW-1:0] LAST = SHW'(WIDTH - 1);

  state_t             state_q, state_d;
  logic [SHW-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic               ov_q, ov_d;       // OutValid
  logic [WIDTH-1:0]   s_q, s_d;
  logic               ovf_q, ovf_d;
  logic               zero_q, zero_d;
  logic               ill_q, ill_d;

  logic [WIDTH-1:0]   core_s;
  logic               core_ovf, core_ill;
  logic               can_load, in_ready, accept, load;
  logic [WIDTH-1:0]   res_s;
  logic               res_ovf, res_ill;
  logic [2*WIDTH-1:0] step_sum;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .a_i       (bus.A),
    .b_i       (bus.B),
    .op_i      (bus.ALUCtrl),
    .s_o       (core_s),
    .ovf_o     (core_ovf),
    .illegal_o (core_ill)
  );

  assign can_load = !ov_q || bus.OutReady;
  assign in_ready = (state_q == IDLE) && can_load;
  assign accept   = bus.InValid && in_ready;
  assign step_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    load     = 1'b0;
    res_s    = core_s;
    res_ovf  = core_ovf;
    res_ill  = core_ill;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (bus.ALUCtrl == OP_MUL) begin
            state_d  = MUL;
            mcand_d  = {{WIDTH{1'b0}}, bus.A};
            mplier_d = bus.B;
            acc_d    = '0;
            cnt_d    = '0;
          end else begin
            load = 1'b1;
          end
        end
      end
      MUL: begin
        if (cnt_q != LAST) begin
          acc_d    = step_sum;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + SHW'(1);
        end else if (can_load) begin
          // Final add is folded into the load; if the old result is still
          // pending, every MUL register holds and this branch retries.
          load    = 1'b1;
          res_s   = step_sum[WIDTH-1:0];
          res_ovf = |step_sum[2*WIDTH-1:WIDTH];
          res_ill = 1'b0;
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ov_d   = ov_q;
    s_d    = s_q;
    ovf_d  = ovf_q;
    zero_d = zero_q;
    ill_d  = ill_q;
    if (load) begin
      ov_d   = 1'b1;
      s_d    = res_s;
      ovf_d  = res_ovf;
      zero_d = (res_s == '0);
      ill_d  = res_ill;
    end else if (bus.OutReady) begin
      ov_d = 1'b0;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      ov_q     <= 1'b0;
      s_q      <= '0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
      ill_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      ov_q     <= ov_d;
      s_q      <= s_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
      ill_q    <= ill_d;
    end
  end

  assign bus.InReady  = in_ready;
  assign bus.OutValid = ov_q;
  assign bus.S        = s_q;
  assign bus.Overflow = ovf_q;
  assign bus.Zero     = zero_q;
  assign bus.Illegal  = ill_q;
endmodule
